// File: rtl/distance_iter_unit.sv
// ============================================================================
// distance_iter_unit : squared / Manhattan / Newton-Euclidean point distance
// Revision 1.0
// ============================================================================
`default_nettype none

module distance_iter_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] y1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] y2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             ovf
);

    localparam int RW = 2 * WIDTH + 1;
    localparam int CW = 4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DIFF = 3'd1,
        S_SUM  = 3'd2,
        S_NEWT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] x1_q, y1_q, x2_q, y2_q;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] dx_q, dy_q;
    logic [RW-1:0]    sq_q, cur_q;
    logic [CW-1:0]    iter_q;
    logic             in_ready_q, out_valid_q, ovf_q;
    logic [WIDTH-1:0] res_q;

    logic [WIDTH-1:0] dx_d, dy_d;
    logic [RW-1:0]    sq_d, cur_d;
    logic [WIDTH:0]   man_d;

    // Clamp a wide raw value to WIDTH bits; MSB of the return is the overflow flag.
    function automatic logic [WIDTH:0] saturate(input logic [RW-1:0] raw);
        if (raw[RW-1:WIDTH] != '0)
            return {1'b1, {WIDTH{1'b1}}};
        else
            return {1'b0, raw[WIDTH-1:0]};
    endfunction

    always_comb begin
        dx_d  = (x1_q >= x2_q) ? (x1_q - x2_q) : (x2_q - x1_q);
        dy_d  = (y1_q >= y2_q) ? (y1_q - y2_q) : (y2_q - y1_q);
        sq_d  = RW'(dx_q) * RW'(dx_q) + RW'(dy_q) * RW'(dy_q);
        man_d = {1'b0, dx_q} + {1'b0, dy_q};
        // Seed is >= sqrt(sq) and the floor step never drops below floor(sqrt),
        // so cur_q is non-zero whenever this result is consumed.
        cur_d = (cur_q + sq_q / cur_q) >> 1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            iter_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x1_q       <= x1;
                        y1_q       <= y1;
                        x2_q       <= x2;
                        y2_q       <= y2;
                        mode_q     <= mode;
                        in_ready_q <= 1'b0;
                        state_q    <= S_DIFF;
                    end
                end
                S_DIFF: begin
                    dx_q    <= dx_d;
                    dy_q    <= dy_d;
                    state_q <= S_SUM;
                end
                S_SUM: begin
                    sq_q <= sq_d;
                    if (!mode_q[1]) begin
                        {ovf_q, res_q} <= saturate(mode_q[0] ? RW'(man_d) : sq_d);
                        out_valid_q    <= 1'b1;
                        state_q        <= S_DONE;
                    end else if (man_d == '0) begin
                        res_q       <= '0;
                        ovf_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cur_q   <= RW'(man_d);
                        iter_q  <= '0;
                        state_q <= S_NEWT;
                    end
                end
                S_NEWT: begin
                    cur_q <= cur_d;
                    if (iter_q == CW'(ITER - 1)) begin
                        {ovf_q, res_q} <= saturate(cur_d);
                        out_valid_q    <= 1'b1;
                        state_q        <= S_DONE;
                    end else begin
                        iter_q <= iter_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign ovf       = ovf_q;

endmodule

`default_nettype wire
